// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the CPU-to-RAM Avalon bridge.
package avalon_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Readdata returned to the CPU when a read is aborted or illegal.
    localparam logic [DATA_W-1:0] ERR_READDATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/wait_timer.sv
// Counts edges on which the downstream slave stalls; flags the edge that hits the limit.
module wait_timer #(
    parameter int unsigned LIMIT = 100,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment so the count starts at zero on every entry.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Look-ahead: true on the stalled edge whose increment reaches LIMIT.
    assign expired = enable && (count_q == CNT_W'(LIMIT - 1));
    assign count   = count_q;

endmodule

// File: rtl/avalon_bus_bridge.sv
// Single-entry registered bridge from the CPU Avalon master to the RAM Avalon slave.
module avalon_bus_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int unsigned        TIMEOUT_CYCLES = 100,
    parameter logic [DATA_W-1:0]  ERR_READDATA   = ERR_READDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    input  logic [BE_W-1:0]   s_byteenable,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              bus_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic              dir_read_q, dir_read_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
    logic [BE_W-1:0]   m_byteenable_q, m_byteenable_d;
    logic [DATA_W-1:0] s_readdata_q, s_readdata_d;
    logic              bus_error_q, bus_error_d;
    logic              s_waitrequest_q, s_waitrequest_d;

    logic              timer_clear;
    logic              timer_enable;
    logic [CNT_W-1:0]  timer_count;
    logic              timer_expired;

    logic              legal_cmd;
    logic              illegal_cmd;

    assign legal_cmd    = s_read ^ s_write;
    assign illegal_cmd  = s_read & s_write;
    assign timer_clear  = (state_q != ISSUE);
    assign timer_enable = (state_q == ISSUE) && m_waitrequest;

    wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .count   (timer_count),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RESP always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (legal_cmd) begin
                    state_d = ISSUE;
                end else if (illegal_cmd) begin
                    state_d = RESP;
                end
            end
            ISSUE: begin
                if (!m_waitrequest || timer_expired) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: capture in IDLE, hold during ISSUE, complete or abort on exit.
    always_comb begin
        dir_read_d      = dir_read_q;
        m_read_d        = m_read_q;
        m_write_d       = m_write_q;
        m_address_d     = m_address_q;
        m_writedata_d   = m_writedata_q;
        m_byteenable_d  = m_byteenable_q;
        s_readdata_d    = s_readdata_q;
        bus_error_d     = bus_error_q;
        s_waitrequest_d = (state_d != RESP);

        case (state_q)
            IDLE: begin
                if (legal_cmd) begin
                    dir_read_d     = s_read;
                    m_read_d       = s_read;
                    m_write_d      = s_write;
                    m_address_d    = s_address;
                    m_writedata_d  = s_writedata;
                    m_byteenable_d = s_byteenable;
                end else if (illegal_cmd) begin
                    bus_error_d  = 1'b1;
                    s_readdata_d = ERR_READDATA;
                end
            end
            ISSUE: begin
                if (!m_waitrequest) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (dir_read_q) begin
                        s_readdata_d = m_readdata;
                    end
                end else if (timer_expired) begin
                    m_read_d    = 1'b0;
                    m_write_d   = 1'b0;
                    bus_error_d = 1'b1;
                    if (dir_read_q) begin
                        s_readdata_d = ERR_READDATA;
                    end
                end
            end
            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_read_q      <= 1'b0;
            m_read_q        <= 1'b0;
            m_write_q       <= 1'b0;
            m_address_q     <= '0;
            m_writedata_q   <= '0;
            m_byteenable_q  <= '0;
            s_readdata_q    <= '0;
            bus_error_q     <= 1'b0;
            s_waitrequest_q <= 1'b1;
        end else begin
            dir_read_q      <= dir_read_d;
            m_read_q        <= m_read_d;
            m_write_q       <= m_write_d;
            m_address_q     <= m_address_d;
            m_writedata_q   <= m_writedata_d;
            m_byteenable_q  <= m_byteenable_d;
            s_readdata_q    <= s_readdata_d;
            bus_error_q     <= bus_error_d;
            s_waitrequest_q <= s_waitrequest_d;
        end
    end

    assign s_waitrequest = s_waitrequest_q;
    assign s_readdata    = s_readdata_q;
    assign m_address     = m_address_q;
    assign m_read        = m_read_q;
    assign m_write       = m_write_q;
    assign m_writedata   = m_writedata_q;
    assign m_byteenable  = m_byteenable_q;
    assign bus_error     = bus_error_q;

    // The abort fires on the edge the count reaches the limit, so it never goes past it.
    count_in_range_a: assert property (@(posedge clk) disable iff (!reset)
        timer_count <= CNT_W'(TIMEOUT_CYCLES));

    // Read and write strobes are mutually exclusive downstream.
    one_hot_cmd_a: assert property (@(posedge clk) disable iff (!reset)
        !(m_read && m_write));

endmodule

// File: tb/tb_avalon_bus_bridge.sv
// Directed bench for avalon_bus_bridge with hand-computed per-cycle expectations.
module tb_avalon_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [3:0]  s_byteenable = '0;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_bus_bridge #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable),
        .s_waitrequest (s_waitrequest),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .bus_error     (bus_error)
    );

    // Assert reset, check values without a clock edge and across one edge, then release.
    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_s_waitrequest: got %b expected 1", s_waitrequest); end
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL rst_m_cmd: got rd=%b wr=%b expected 0 0", m_read, m_write); end
        checks++; if (m_address !== 32'h0 || m_writedata !== 32'h0 || m_byteenable !== 4'h0) begin errors++; $display("FAIL rst_m_fields: got %h %h %h expected zeros", m_address, m_writedata, m_byteenable); end
        checks++; if (s_readdata !== 32'h0) begin errors++; $display("FAIL rst_s_readdata: got %h expected 00000000", s_readdata); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error: got %b expected 0", bus_error); end
        @(posedge clk); #1;
        checks++; if (s_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL rst_held: got wait=%b rd=%b expected 1 0", s_waitrequest, m_read); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Zero-wait read: RESP in cycle 2 only, readdata registered from RAM.
    task automatic test_read_zero_wait(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            s_read = (c <= 2); s_write = 1'b0; s_address = addr;
            m_waitrequest = 1'b0; m_readdata = data;
            @(negedge clk);
            checks++; if (s_waitrequest !== (c != 2)) begin errors++; $display("FAIL rd_s_waitrequest c%0d: got %b expected %b", c, s_waitrequest, (c != 2)); end
            checks++; if (m_read !== (c == 1) || m_write !== 1'b0) begin errors++; $display("FAIL rd_m_cmd c%0d: got rd=%b wr=%b expected %b 0", c, m_read, m_write, (c == 1)); end
            checks++; if (bus_error !== exp_err) begin errors++; $display("FAIL rd_bus_error c%0d: got %b expected %b", c, bus_error, exp_err); end
            if (c == 1) begin
                checks++; if (m_address !== addr) begin errors++; $display("FAIL rd_m_address: got %h expected %h", m_address, addr); end
            end
            if (c >= 2) begin
                checks++; if (s_readdata !== data) begin errors++; $display("FAIL rd_s_readdata c%0d: got %h expected %h", c, s_readdata, data); end
            end
        end
    endtask

    // Write with three stalled edges: m_write high four cycles, fields stable, readdata untouched.
    task automatic test_write_waits();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            s_write = (c <= 5); s_read = 1'b0;
            s_address = 32'h20; s_writedata = 32'hCAFE_F00D; s_byteenable = 4'b0011;
            m_waitrequest = (c < 4); m_readdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++; if (m_write !== (c >= 1 && c <= 4) || m_read !== 1'b0) begin errors++; $display("FAIL wr_m_cmd c%0d: got wr=%b rd=%b expected %b 0", c, m_write, m_read, (c >= 1 && c <= 4)); end
            checks++; if (s_waitrequest !== (c != 5)) begin errors++; $display("FAIL wr_s_waitrequest c%0d: got %b expected %b", c, s_waitrequest, (c != 5)); end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL wr_bus_error c%0d: got %b expected 0", c, bus_error); end
            checks++; if (s_readdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_s_readdata c%0d: got %h expected 12345678", c, s_readdata); end
            if (c >= 1 && c <= 4) begin
                checks++; if (m_address !== 32'h20 || m_writedata !== 32'hCAFE_F00D || m_byteenable !== 4'b0011) begin errors++; $display("FAIL wr_fields c%0d: got %h %h %b expected 00000020 cafef00d 0011", c, m_address, m_writedata, m_byteenable); end
            end
        end
        m_waitrequest = 1'b0;
    endtask

    // Read and write together: nothing downstream, error flagged, one-cycle RESP.
    task automatic test_illegal();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            s_read = (c <= 1); s_write = (c <= 1); s_address = 32'h30;
            @(negedge clk);
            checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL ill_m_cmd c%0d: got rd=%b wr=%b expected 0 0", c, m_read, m_write); end
            checks++; if (s_waitrequest !== (c != 1)) begin errors++; $display("FAIL ill_s_waitrequest c%0d: got %b expected %b", c, s_waitrequest, (c != 1)); end
            checks++; if (bus_error !== (c >= 1)) begin errors++; $display("FAIL ill_bus_error c%0d: got %b expected %b", c, bus_error, (c >= 1)); end
            if (c >= 1) begin
                checks++; if (s_readdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ill_s_readdata c%0d: got %h expected ffffffff", c, s_readdata); end
            end
        end
    endtask

    // Stuck slave with limit 4: m_read high four cycles, then abort with error data.
    task automatic test_timeout();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            s_read = (c <= 5); s_write = 1'b0; s_address = 32'h40;
            m_waitrequest = 1'b1; m_readdata = 32'h5555_5555;
            @(negedge clk);
            checks++; if (m_read !== (c >= 1 && c <= 4) || m_write !== 1'b0) begin errors++; $display("FAIL to_m_cmd c%0d: got rd=%b wr=%b expected %b 0", c, m_read, m_write, (c >= 1 && c <= 4)); end
            checks++; if (s_waitrequest !== (c != 5)) begin errors++; $display("FAIL to_s_waitrequest c%0d: got %b expected %b", c, s_waitrequest, (c != 5)); end
            checks++; if (bus_error !== (c >= 5)) begin errors++; $display("FAIL to_bus_error c%0d: got %b expected %b", c, bus_error, (c >= 5)); end
            if (c >= 5) begin
                checks++; if (s_readdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_s_readdata c%0d: got %h expected ffffffff", c, s_readdata); end
            end
        end
        m_waitrequest = 1'b0;
    endtask

    // Successful zero-wait write after an error: flag stays set, readdata unchanged.
    task automatic test_sticky_error();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            s_write = (c <= 2); s_read = 1'b0; s_address = 32'h50;
            s_writedata = 32'h0BAD_F00D; s_byteenable = 4'b1111; m_waitrequest = 1'b0;
            @(negedge clk);
            checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL sticky_bus_error c%0d: got %b expected 1", c, bus_error); end
            checks++; if (s_readdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sticky_s_readdata c%0d: got %h expected ffffffff", c, s_readdata); end
            checks++; if (s_waitrequest !== (c != 2)) begin errors++; $display("FAIL sticky_s_waitrequest c%0d: got %b expected %b", c, s_waitrequest, (c != 2)); end
        end
    endtask

    // Reset during ISSUE: command dropped at once, no RESP, next read normal.
    task automatic test_reset_mid_issue();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            s_read = 1'b1; s_write = 1'b0; s_address = 32'h80; m_waitrequest = 1'b1;
            @(negedge clk);
        end
        checks++; if (m_read !== 1'b1) begin errors++; $display("FAIL mid_pre_m_read: got %b expected 1", m_read); end
        #2 reset = 1'b0;
        #1;
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL mid_m_cmd: got rd=%b wr=%b expected 0 0", m_read, m_write); end
        checks++; if (m_address !== 32'h0 || m_writedata !== 32'h0 || m_byteenable !== 4'h0) begin errors++; $display("FAIL mid_m_fields: got %h %h %h expected zeros", m_address, m_writedata, m_byteenable); end
        checks++; if (s_readdata !== 32'h0 || bus_error !== 1'b0 || s_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_s_side: got rd=%h err=%b wait=%b expected 00000000 0 1", s_readdata, bus_error, s_waitrequest); end
        s_read = 1'b0; m_waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL mid_no_resp: got wait=%b rd=%b expected 1 0", s_waitrequest, m_read); end
        @(negedge clk);
        test_read_zero_wait(32'h84, 32'hAABB_CCDD, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_zero_wait(32'h10, 32'h1234_5678, 1'b0);
        test_write_waits();
        test_illegal();
        test_reset();
        test_timeout();
        test_sticky_error();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
